// File: rtl/packet_commit_ctrl.sv
// Packet commit controller: pushes packet words into a ring buffer, checks the trailing checksum and commits or rolls back.
// Optional idle timeout in RECV/DROP is compiled in when the macro PKT_TIMEOUT_EN is defined.
module packet_commit_ctrl #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int CAPACITY    = 255,
    parameter int MAX_LEN     = 32,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_first,
    input  logic              in_last,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] rb_mem_used,
    output logic              rb_open,
    output logic              rb_commit,
    output logic              rb_rollback,
    output logic              push_request,
    output logic [DATA_W-1:0] push_data,
    input  logic              push_done,
    output logic              pkt_ok,
    output logic              pkt_err,
    output logic [1:0]        err_code
);

    localparam int PEND_W = $clog2(MAX_LEN + 1);
    localparam int USE_W  = ADDR_W + 1;

    localparam logic [1:0] ERR_CSUM     = 2'd0;
    localparam logic [1:0] ERR_FRAME    = 2'd1;
    localparam logic [1:0] ERR_OVERFLOW = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        PUSH,
        RECV,
        CHECK,
        COMMIT,
        ROLLBACK,
        DROP
    } state_t;

    state_t            state_reg, state_next;
    logic [DATA_W-1:0] data_reg, data_next;
    logic [DATA_W-1:0] sum_reg, sum_next;
    logic [DATA_W-1:0] csum_reg, csum_next;
    logic [PEND_W-1:0] pend_reg, pend_next;
    logic [1:0]        err_reg, err_next;
    logic              open_reg, open_next;
    logic              frame_reg, frame_next;

    logic              in_accept;
    logic              has_room;
    logic [USE_W-1:0]  occupancy;
    logic              timeout_hit;

    assign in_accept = in_valid & in_ready;

    // Room check uses the live committed count plus words already pushed but not yet committed.
    assign occupancy = {1'b0, rb_mem_used} + USE_W'(pend_reg);
    assign has_room  = (pend_reg < PEND_W'(MAX_LEN)) && (occupancy < USE_W'(CAPACITY));

`ifdef PKT_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] idle_cnt_reg, idle_cnt_next;
    logic            waiting;

    assign waiting     = (state_reg == RECV) || (state_reg == DROP);
    assign timeout_hit = waiting && !in_accept && (idle_cnt_reg == TO_W'(TIMEOUT_CYC - 1));

    always_comb begin
        idle_cnt_next = '0;
        if (waiting && !in_accept && !timeout_hit) begin
            idle_cnt_next = idle_cnt_reg + TO_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt_reg <= '0;
        end else begin
            idle_cnt_reg <= idle_cnt_next;
        end
    end
`else
    // TIMEOUT_CYC has no effect without the timeout feature.
    logic timeout_cfg_unused;
    assign timeout_cfg_unused = (TIMEOUT_CYC != 0);
    assign timeout_hit        = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        data_next  = data_reg;
        sum_next   = sum_reg;
        csum_next  = csum_reg;
        pend_next  = pend_reg;
        err_next   = err_reg;
        open_next  = 1'b0;
        frame_next = 1'b0;

        unique case (state_reg)
            IDLE: begin
                if (in_accept && in_first) begin
                    if (in_last) begin
                        // A packet with no data words is reported but never opened.
                        frame_next = 1'b1;
                        err_next   = ERR_FRAME;
                    end else begin
                        data_next  = in_data;
                        sum_next   = '0;
                        pend_next  = '0;
                        open_next  = 1'b1;
                        state_next = PUSH;
                    end
                end
            end
            PUSH: begin
                if (push_done) begin
                    sum_next   = sum_reg + data_reg;
                    pend_next  = pend_reg + PEND_W'(1);
                    state_next = RECV;
                end
            end
            RECV: begin
                if (in_accept) begin
                    if (in_first) begin
                        err_next   = ERR_FRAME;
                        state_next = ROLLBACK;
                    end else if (in_last) begin
                        csum_next  = in_data;
                        state_next = CHECK;
                    end else if (has_room) begin
                        data_next  = in_data;
                        state_next = PUSH;
                    end else begin
                        err_next   = ERR_OVERFLOW;
                        state_next = DROP;
                    end
                end
            end
            CHECK: begin
                if (sum_reg == csum_reg) begin
                    state_next = COMMIT;
                end else begin
                    err_next   = ERR_CSUM;
                    state_next = ROLLBACK;
                end
            end
            COMMIT: begin
                state_next = IDLE;
            end
            ROLLBACK: begin
                state_next = IDLE;
            end
            DROP: begin
                if (in_accept && in_last) begin
                    state_next = ROLLBACK;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (timeout_hit) begin
            err_next   = ERR_TIMEOUT;
            state_next = ROLLBACK;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            data_reg  <= '0;
            sum_reg   <= '0;
            csum_reg  <= '0;
            pend_reg  <= '0;
            err_reg   <= ERR_CSUM;
            open_reg  <= 1'b0;
            frame_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            data_reg  <= data_next;
            sum_reg   <= sum_next;
            csum_reg  <= csum_next;
            pend_reg  <= pend_next;
            err_reg   <= err_next;
            open_reg  <= open_next;
            frame_reg <= frame_next;
        end
    end

    // in_ready is gated by rst so every output reads 0 while reset is held.
    assign in_ready     = ~rst && ((state_reg == IDLE) || (state_reg == RECV) || (state_reg == DROP));
    assign push_request = (state_reg == PUSH);
    assign push_data    = data_reg;
    assign rb_open      = open_reg;
    assign rb_commit    = (state_reg == COMMIT);
    assign rb_rollback  = (state_reg == ROLLBACK);
    assign pkt_ok       = (state_reg == COMMIT);
    assign pkt_err      = (state_reg == ROLLBACK) || frame_reg;
    assign err_code     = pkt_err ? err_reg : 2'd0;

endmodule

// File: tb/tb_packet_commit_ctrl.sv
// Directed bench for packet_commit_ctrl with a packet-level reference model and per-cycle output checks.
// Timeout cases are exercised only when PKT_TIMEOUT_EN is defined.
module tb_packet_commit_ctrl;

    localparam int DATA_W      = 16;
    localparam int ADDR_W      = 16;
    localparam int CAPACITY    = 8;
    localparam int MAX_LEN     = 4;
    localparam int TIMEOUT_CYC = 16;
`ifdef PKT_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_first = 1'b0;
    logic              in_last = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_ready;
    logic [ADDR_W-1:0] rb_mem_used = '0;
    logic              rb_open, rb_commit, rb_rollback;
    logic              push_request;
    logic [DATA_W-1:0] push_data;
    logic              push_done = 1'b0;
    logic              pkt_ok, pkt_err;
    logic [1:0]        err_code;

    packet_commit_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CAPACITY(CAPACITY),
        .MAX_LEN(MAX_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_first(in_first), .in_last(in_last), .in_data(in_data),
        .in_ready(in_ready), .rb_mem_used(rb_mem_used),
        .rb_open(rb_open), .rb_commit(rb_commit), .rb_rollback(rb_rollback),
        .push_request(push_request), .push_data(push_data), .push_done(push_done),
        .pkt_ok(pkt_ok), .pkt_err(pkt_err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    // Ring-buffer write responder: completes each push after push_lat extra cycles.
    int push_lat = 0;
    int wait_cnt = 0;
    always @(posedge clk) begin
        #1;
        if (push_request && !push_done) begin
            if (wait_cnt >= push_lat) push_done = 1'b1;
            else wait_cnt++;
        end else begin
            push_done = 1'b0;
            wait_cnt  = 0;
        end
    end

    int total = 0, bad = 0;
    int cyc = 0, open_cnt = 0, commit_cnt = 0, rollback_cnt = 0, ok_cnt = 0, err_cnt = 0;
    int push_cyc = 0, rb_cyc = 0;
    logic [1:0] last_code = 2'd0;
    bit txn_open = 1'b0;
    logic [DATA_W-1:0] act_push[$];

    logic [DATA_W-1:0] q_data[$];
    bit q_first[$];
    bit q_last[$];

    logic [DATA_W-1:0] m_push[$];
    int m_open, m_commit, m_rollback, m_ok, m_err;
    logic [1:0] m_code;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic sample();
        cyc++;
        chk("one_txn_pulse", ((int'(rb_open) + int'(rb_commit) + int'(rb_rollback)) > 1), 0);
        chk("ok_with_commit", pkt_ok, rb_commit);
        chk("err_with_rollback", rb_rollback & ~pkt_err, 0);
        chk("push_holdoff", push_request & in_ready, 0);
        if (rb_open) begin
            chk("open_while_open", txn_open, 0);
            txn_open = 1'b1;
            open_cnt++;
        end
        if (rb_commit || rb_rollback) begin
            chk("end_without_open", txn_open, 1);
            txn_open = 1'b0;
        end
        if (rb_commit) commit_cnt++;
        if (rb_rollback) begin
            rollback_cnt++;
            rb_cyc = cyc;
        end
        if (pkt_ok) ok_cnt++;
        if (pkt_err) begin
            err_cnt++;
            last_code = err_code;
        end
        if (push_request && push_done) begin
            act_push.push_back(push_data);
            push_cyc = cyc;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (!rst) sample();
    endtask

    task automatic add(input logic [DATA_W-1:0] d, input bit f, input bit l);
        q_data.push_back(d);
        q_first.push_back(f);
        q_last.push_back(l);
    endtask

    // Packet-level model: walks the word list and decides pushes and the final outcome.
    task automatic model(input int mem);
        int st;
        int pend;
        logic [DATA_W-1:0] sum;
        st = 0; pend = 0; sum = '0;
        m_push.delete();
        m_open = 0; m_commit = 0; m_rollback = 0; m_ok = 0; m_err = 0; m_code = 2'd0;
        for (int i = 0; i < q_data.size(); i++) begin
            if (st == 0) begin
                if (q_first[i] && q_last[i]) begin
                    m_err++; m_code = 2'd1;
                end else if (q_first[i]) begin
                    m_open++;
                    m_push.push_back(q_data[i]);
                    sum = q_data[i]; pend = 1; st = 1;
                end
            end else if (st == 2) begin
                if (q_last[i]) begin
                    m_rollback++; m_err++; m_code = 2'd2; st = 0;
                end
            end else begin
                if (q_first[i]) begin
                    m_rollback++; m_err++; m_code = 2'd1; st = 0;
                end else if (q_last[i]) begin
                    if (sum == q_data[i]) begin
                        m_commit++; m_ok++;
                    end else begin
                        m_rollback++; m_err++; m_code = 2'd0;
                    end
                    st = 0;
                end else if (pend < MAX_LEN && mem + pend < CAPACITY) begin
                    m_push.push_back(q_data[i]);
                    sum = sum + q_data[i];
                    pend++;
                end else begin
                    st = 2;
                end
            end
        end
        if (st != 0 && TO_EN) begin
            m_rollback++; m_err++; m_code = 2'd3;
        end
    endtask

    task automatic send_word(input logic [DATA_W-1:0] d, input bit f, input bit l);
        int n;
        n = 0;
        in_valid = 1'b1; in_data = d; in_first = f; in_last = l;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        chk("word_accept_wait", (n < 50), 1);
        tick();
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    endtask

    task automatic run_pkt(input string name, input int mem, input int lat, input int gap);
        int o0, c0, r0, k0, e0, p0, n;
        rb_mem_used = ADDR_W'(mem);
        push_lat = lat;
        o0 = open_cnt; c0 = commit_cnt; r0 = rollback_cnt; k0 = ok_cnt; e0 = err_cnt;
        p0 = act_push.size();
        model(mem);
        for (int i = 0; i < q_data.size(); i++) begin
            send_word(q_data[i], q_first[i], q_last[i]);
            repeat (gap) tick();
        end
        n = 0;
        while ((ok_cnt + err_cnt) == (k0 + e0) && n < 60) begin
            tick();
            n++;
        end
        chk({name, "_end_seen"}, (n < 60), 1);
        repeat (4) tick();
        chk({name, "_opens"}, open_cnt - o0, m_open);
        chk({name, "_commits"}, commit_cnt - c0, m_commit);
        chk({name, "_rollbacks"}, rollback_cnt - r0, m_rollback);
        chk({name, "_pkt_ok"}, ok_cnt - k0, m_ok);
        chk({name, "_pkt_err"}, err_cnt - e0, m_err);
        chk({name, "_push_count"}, act_push.size() - p0, m_push.size());
        for (int i = 0; i < m_push.size(); i++) begin
            if (p0 + i < act_push.size())
                chk($sformatf("%s_push%0d", name, i), act_push[p0 + i], m_push[i]);
        end
        if (m_err > 0) chk({name, "_err_code"}, last_code, m_code);
        chk({name, "_txn_closed"}, txn_open, 0);
        $display("pkt %s: opens=%0d pushes=%0d commits=%0d rollbacks=%0d errs=%0d code=%0d",
                 name, open_cnt - o0, act_push.size() - p0, commit_cnt - c0,
                 rollback_cnt - r0, err_cnt - e0, last_code);
        q_data.delete(); q_first.delete(); q_last.delete();
        push_lat = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, r0;
        #1;
        chk("rst_outputs_zero", {in_ready, rb_open, rb_commit, rb_rollback, push_request,
                                 push_data, pkt_ok, pkt_err, err_code}, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("in_ready_after_rst", in_ready, 1);
        tick();
        chk("idle_no_push", push_request, 0);

        // good packet: 1 + 2 = 3
        add(16'h0001, 1, 0); add(16'h0002, 0, 0); add(16'h0003, 0, 1);
        run_pkt("good", 0, 0, 0);
        chk("good_pin_pushes", m_push.size(), 2);
        chk("good_pin_commit", m_commit, 1);

        add(16'h0001, 1, 0); add(16'h0002, 0, 0); add(16'h0004, 0, 1);
        run_pkt("csum", 0, 1, 0);
        chk("csum_pin_rollback", m_rollback, 1);
        chk("csum_pin_code", m_code, 0);

        add(16'h0010, 1, 0); add(16'h0020, 0, 0); add(16'h0030, 0, 1);
        run_pkt("full_rb", 7, 0, 0);
        chk("full_rb_pin_pushes", m_push.size(), 1);
        chk("full_rb_pin_code", m_code, 2);

        add(16'h0001, 1, 0); add(16'h0002, 0, 0); add(16'h0003, 0, 0);
        add(16'h0004, 0, 0); add(16'h0005, 0, 0); add(16'h000F, 0, 1);
        run_pkt("too_long", 0, 0, 0);
        chk("too_long_pin_pushes", m_push.size(), 4);
        chk("too_long_pin_code", m_code, 2);

        add(16'h0042, 1, 1);
        run_pkt("lone_word", 0, 0, 0);
        chk("lone_word_pin_open", m_open, 0);
        chk("lone_word_pin_code", m_code, 1);

        add(16'h0001, 1, 0); add(16'h0002, 0, 0); add(16'h0007, 1, 0);
        run_pkt("first_in_body", 0, 0, 0);

        add(16'h0009, 0, 1); add(16'h0004, 0, 0);
        add(16'h0001, 1, 0); add(16'h0002, 0, 0); add(16'h0003, 0, 1);
        run_pkt("stray_words", 0, 0, 0);

        // 0x8000 + 0x8001 wraps to 0x0001
        add(16'h8000, 1, 0); add(16'h8001, 0, 0); add(16'h0001, 0, 1);
        run_pkt("wrap_sum", 0, 2, 2);
        chk("wrap_sum_pin_commit", m_commit, 1);

        add(16'h0001, 1, 0); add(16'h0002, 0, 0); add(16'h0003, 0, 1);
        run_pkt("edge_fit", 6, 1, 0);

        add(16'h0001, 1, 0); add(16'h0002, 0, 0); add(16'h0003, 0, 0); add(16'h0006, 0, 1);
        run_pkt("edge_over", 6, 0, 1);
        chk("edge_over_pin_pushes", m_push.size(), 2);

        add(16'h0001, 1, 0); add(16'h0002, 0, 0); add(16'h0003, 0, 0);
        add(16'h0004, 0, 0); add(16'h000A, 0, 1);
        run_pkt("max_len", 0, 0, 0);
        chk("max_len_pin_commit", m_commit, 1);

`ifdef PKT_TIMEOUT_EN
        add(16'h0077, 1, 0);
        run_pkt("timeout", 0, 0, 0);
        chk("timeout_pin_code", m_code, 3);
        chk("timeout_latency", rb_cyc - push_cyc, TIMEOUT_CYC + 1);
`else
        add(16'h0021, 1, 0); add(16'h0021, 0, 1);
        run_pkt("long_wait", 0, 0, 40);
        chk("long_wait_pin_commit", m_commit, 1);
`endif

        // reset while a push is outstanding
        rb_mem_used = '0;
        push_lat = 6;
        send_word(16'h0055, 1, 0);
        chk("mid_push_req", push_request, 1);
        c0 = commit_cnt;
        r0 = rollback_cnt;
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_push_zero", {in_ready, rb_open, rb_commit, rb_rollback, push_request,
                                  push_data, pkt_ok, pkt_err, err_code}, 0);
        @(negedge clk);
        @(negedge clk);
        txn_open = 1'b0;
        push_lat = 0;
        #2 rst = 1'b0;
        #1;
        chk("in_ready_after_mid_rst", in_ready, 1);
        repeat (10) tick();
        chk("rst_no_commit", commit_cnt - c0, 0);
        chk("rst_no_rollback", rollback_cnt - r0, 0);
        $display("reset mid-push: commits=%0d rollbacks=%0d", commit_cnt - c0, rollback_cnt - r0);

        add(16'h0003, 1, 0); add(16'h0003, 0, 1);
        run_pkt("after_rst", 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
